// File: rtl/hamming_decode_pipe_if.sv
// Handshake bundle for the Hamming(21,16) decoder: codeword in, corrected message and status out.
// The decoder takes the slave view and the codeword source takes the master view.
interface hamming_decode_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorrectable;

    modport slave (
        input  in_valid,
        input  in_code,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_syndrome,
        output out_corrected,
        output out_uncorrectable
    );

    modport master (
        output in_valid,
        output in_code,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_syndrome,
        input  out_corrected,
        input  out_uncorrectable
    );
endinterface

// File: rtl/hamming_decode_pipe.sv
// Two-stage Hamming(21,16) SEC decoder with valid/ready flow control on both sides.
// It also keeps saturating counts of corrected and uncorrectable words.
module hamming_decode_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_decode_pipe_if.slave bus,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);

    // Position p (1..21) lives at code[p-1]; the syndrome is the XOR of all set positions.
    function automatic logic [4:0] calc_syndrome(input logic [20:0] code);
        logic [4:0] s;
        s = '0;
        for (int p = 1; p <= 21; p++) begin
            if (code[p-1]) s = s ^ 5'(p);
        end
        return s;
    endfunction

    function automatic logic [15:0] extract_data(input logic [20:0] code);
        return {code[20:16], code[14:8], code[6:4], code[2]};
    endfunction

    logic             v1_q, v1_d;
    logic [20:0]      code1_q, code1_d;
    logic [4:0]       syn1_q, syn1_d;

    logic             v2_q, v2_d;
    logic [15:0]      data_q, data_d;
    logic [4:0]       syn2_q, syn2_d;
    logic             corr_q, corr_d;
    logic             uncorr_q, uncorr_d;

    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic             adv1, adv2, in_hs, out_hs;
    logic             s1_corr, s1_uncorr;
    logic [20:0]      flip_mask;

    assign adv2   = ~v2_q | bus.out_ready;
    assign adv1   = ~v1_q | adv2;
    assign in_hs  = bus.in_valid & adv1 & ~rst;
    assign out_hs = v2_q & bus.out_ready;

    assign s1_corr   = (syn1_q != 5'd0) && (syn1_q <= 5'd21);
    assign s1_uncorr = (syn1_q > 5'd21);
    assign flip_mask = s1_corr ? (21'd1 << (syn1_q - 5'd1)) : '0;

    always_comb begin
        v1_d    = v1_q;
        code1_d = code1_q;
        syn1_d  = syn1_q;
        if (adv1) v1_d = bus.in_valid;
        if (in_hs) begin
            code1_d = bus.in_code;
            syn1_d  = calc_syndrome(bus.in_code);
        end
    end

    // S2 only reloads its payload when S1 holds a word, so outputs keep their last value.
    always_comb begin
        v2_d     = v2_q;
        data_d   = data_q;
        syn2_d   = syn2_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (adv2) v2_d = v1_q;
        if (adv2 && v1_q) begin
            data_d   = extract_data(code1_q ^ flip_mask);
            syn2_d   = syn1_q;
            corr_d   = s1_corr;
            uncorr_d = s1_uncorr;
        end
    end

    // Clear wins over a same-cycle increment; both counters saturate at all-ones.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_hs) begin
            if (corr_q && (corr_cnt_q != {CNT_W{1'b1}})) corr_cnt_d = corr_cnt_q + 1'b1;
            if (uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            code1_q      <= '0;
            syn1_q       <= '0;
            v2_q         <= 1'b0;
            data_q       <= '0;
            syn2_q       <= '0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            v1_q         <= v1_d;
            code1_q      <= code1_d;
            syn1_q       <= syn1_d;
            v2_q         <= v2_d;
            data_q       <= data_d;
            syn2_q       <= syn2_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.in_ready          = adv1 & ~rst;
    assign bus.out_valid         = v2_q;
    assign bus.out_data          = data_q;
    assign bus.out_syndrome      = syn2_q;
    assign bus.out_corrected     = corr_q;
    assign bus.out_uncorrectable = uncorr_q;
    assign corr_cnt              = corr_cnt_q;
    assign uncorr_cnt            = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_decode_pipe.sv
// Scoreboard bench for hamming_decode_pipe: reference decoder, directed vectors, backpressure,
// throughput, mid-stream reset, random traffic and a narrow-counter instance for saturation.
module tb_hamming_decode_pipe;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  syn;
        logic        corr;
        logic        unc;
        int          cyc;
    } exp_t;

    localparam logic [20:0] CleanCode = 21'h0A786C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_cnt = 1'b0;
    logic clr_cnt2 = 1'b0;
    logic [15:0] corr_cnt, uncorr_cnt;
    logic [1:0]  corr_cnt2, uncorr_cnt2;

    hamming_decode_pipe_if bus ();
    hamming_decode_pipe_if bus2 ();

    hamming_decode_pipe #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    hamming_decode_pipe #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus2),
        .clr_cnt    (clr_cnt2),
        .corr_cnt   (corr_cnt2),
        .uncorr_cnt (uncorr_cnt2)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decoder: syndrome as XOR of set positions, flip, then read non-power-of-two slots.
    function automatic exp_t ref_decode(input logic [20:0] code);
        exp_t e;
        int s;
        int k;
        logic [20:0] w;
        s = 0;
        k = 0;
        for (int p = 1; p <= 21; p++) if (code[p-1]) s = s ^ p;
        w = code;
        e.corr = (s >= 1) && (s <= 21);
        e.unc  = (s > 21);
        if (e.corr) w[s-1] = ~w[s-1];
        e.data = '0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                e.data[k] = w[p-1];
                k++;
            end
        end
        e.syn = 5'(s);
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [20:0] encode(input logic [15:0] m);
        logic [20:0] w;
        int k;
        int s;
        w = '0;
        k = 0;
        s = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p-1] = m[k];
                if (m[k]) s = s ^ p;
                k++;
            end
        end
        for (int i = 0; i < 5; i++) if (s[i]) w[(1 << i) - 1] = 1'b1;
        return w;
    endfunction

    function automatic logic [20:0] rand_code();
        logic [20:0] w;
        int r;
        int a;
        int b;
        w = encode(16'($urandom));
        r = $urandom_range(0, 9);
        a = $urandom_range(0, 20);
        b = (a + $urandom_range(1, 20)) % 21;
        if (r < 4) w[a] = ~w[a];
        else if (r < 6) begin
            w[a] = ~w[a];
            w[b] = ~w[b];
        end else if (r == 6) w = 21'($urandom);
        return w;
    endfunction

    logic [15:0] held_data;
    logic [4:0]  held_syn;
    logic        held_corr, held_unc;
    bit          have_hold = 1'b0;
    int          exp_corr = 0;
    int          exp_unc = 0;

    // Monitor: pops on every output handshake, tracks counters, checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        cyc++;
        if (rst) begin
            q.delete();
            exp_corr  = 0;
            exp_unc   = 0;
            have_hold = 1'b0;
        end else begin
            chk("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
            chk("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_unc));
            if (have_hold && bus.out_valid) begin
                chk("hold_data", 32'(bus.out_data), 32'(held_data));
                chk("hold_flags", {bus.out_syndrome, bus.out_corrected, bus.out_uncorrectable},
                    {held_syn, held_corr, held_unc});
            end
            have_hold = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            held_syn  = bus.out_syndrome;
            held_corr = bus.out_corrected;
            held_unc  = bus.out_uncorrectable;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_output", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.data));
                    chk("out_syndrome", 32'(bus.out_syndrome), 32'(e.syn));
                    chk("out_corrected", 32'(bus.out_corrected), 32'(e.corr));
                    chk("out_uncorrectable", 32'(bus.out_uncorrectable), 32'(e.unc));
                    if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd2);
                    if (e.corr && exp_corr != 65535) exp_corr++;
                    if (e.unc && exp_unc != 65535) exp_unc++;
                end
            end
            if (clr_cnt) begin
                exp_corr = 0;
                exp_unc  = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                n = ref_decode(bus.in_code);
                n.cyc = cyc;
                q.push_back(n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input logic [20:0] code, input logic [15:0] d, input logic [4:0] s,
                            input logic c, input logic u);
        int w;
        tick();
        bus.in_valid  = 1'b1;
        bus.in_code   = code;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.out_valid && w < 10);
        chk("dir_valid", 32'(bus.out_valid), 32'd1);
        chk("dir_data", 32'(bus.out_data), 32'(d));
        chk("dir_syndrome", 32'(bus.out_syndrome), 32'(s));
        chk("dir_flags", {bus.out_corrected, bus.out_uncorrectable}, {c, u});
    endtask

    task automatic drain();
        int w;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clr_cnt       = 1'b0;
        w = 0;
        while (q.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int w;
        bit hs;
        logic [20:0] words[4];

        bus.in_valid   = 1'b0;
        bus.in_code    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_code   = '0;
        bus2.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_counters", {corr_cnt, uncorr_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed vectors
        send_chk(CleanCode, 16'h578D, 5'd0, 1'b0, 1'b0);
        for (int p = 1; p <= 21; p++) begin
            send_chk(CleanCode ^ (21'd1 << (p - 1)), 16'h578D, 5'(p), 1'b1, 1'b0);
        end
        send_chk(21'h1A786E, 16'hD78D, 5'd23, 1'b0, 1'b1);
        drain();
        chk("dir_corr_total", 32'(corr_cnt), 32'd21);
        chk("dir_uncorr_total", 32'(uncorr_cnt), 32'd1);

        // Backpressure: 4 words against a stalled output for 5 cycles
        for (int i = 0; i < 4; i++) words[i] = rand_code();
        bus.out_ready = 1'b0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = words[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            hs = bus.in_ready;
            tick();
            if (hs) acc++;
            bus.in_code = words[acc];
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.out_ready = 1'b1;
        w = 0;
        while (acc < 4 && w < 20) begin
            @(negedge clk);
            hs = bus.in_ready;
            tick();
            if (hs) acc++;
            if (acc < 4) bus.in_code = words[acc];
            w++;
        end
        chk("bp_all_accepted", 32'(acc), 32'd4);
        drain();

        // Throughput: back-to-back with fixed 2-cycle latency
        lat_chk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = rand_code();
            tick();
        end
        drain();
        lat_chk = 1'b0;

        // Reset mid-stream
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = CleanCode ^ (21'd1 << i);
            tick();
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_counters", {corr_cnt, uncorr_cnt}, 32'd0);
        tick();

        // Random traffic with random backpressure and occasional clears
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            tick();
            if (hs || !bus.in_valid) begin
                bus.in_valid = 1'($urandom_range(0, 3) != 0);
                bus.in_code  = rand_code();
            end
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            clr_cnt       = 1'($urandom_range(0, 40) == 0);
        end
        drain();

        // Narrow counter: saturation and clear-over-increment
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_code  = CleanCode ^ (21'd1 << (i + 2));
            tick();
        end
        bus2.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_corr_cnt", 32'(corr_cnt2), 32'd3);
        chk("sat_uncorr_cnt", 32'(uncorr_cnt2), 32'd0);
        bus2.out_ready = 1'b0;
        bus2.in_valid  = 1'b1;
        bus2.in_code   = CleanCode ^ 21'h100;
        tick();
        bus2.in_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus2.out_valid && w < 10);
        chk("clr_pre_valid", 32'(bus2.out_valid), 32'd1);
        chk("clr_pre_corr", 32'(bus2.out_corrected), 32'd1);
        tick();
        clr_cnt2       = 1'b1;
        bus2.out_ready = 1'b1;
        tick();
        clr_cnt2 = 1'b0;
        @(negedge clk);
        chk("clr_vs_incr", 32'(corr_cnt2), 32'd0);
        chk("clr_consumed", 32'(bus2.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_decode_pipe.md
Name: hamming_decode_pipe

Overview:
- Receiver-side companion to the 16-bit Hamming encoder; sits directly downstream of it.
- Consumes the 21-bit Hamming(21,16) codeword `y` produced by the encoder (possibly corrupted in transit).
- Computes the syndrome, corrects any single-bit error, flags uncorrectable syndromes, and returns the 16-bit message.
- Two-stage pipeline with valid/ready flow control on both sides, plus saturating error-statistics counters.

Parameters:
- CNT_W, 16, width of the corrected and uncorrectable event counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream codeword valid
- in_ready  out  1  block can accept a codeword this cycle
- in_code  in  21  codeword, encoder format (bit map in Behaviour)
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  16  corrected message m[15:0]
- out_syndrome  out  5  raw syndrome of this word
- out_corrected  out  1  syndrome in 1..21; one bit was flipped
- out_uncorrectable  out  1  syndrome in 22..31; data passed uncorrected
- clr_cnt  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  count of accepted results with out_corrected=1
- uncorr_cnt  out  CNT_W  count of accepted results with out_uncorrectable=1

Behaviour:
- Codeword format: position p (1..21) is in_code[p-1].
  - Parity bits sit at p = 1, 2, 4, 8, 16.
  - Data bits fill the remaining positions in ascending order: m[0] at p3, m[3:1] at p5..7, m[10:4] at p9..15, m[15:11] at p17..21.
  - Even parity: the XOR of the indices of all set positions is 0 for a clean word.
- Syndrome: s = XOR of indices p of all set bits in in_code, 5 bits wide.
  - s = 0: no error; data extracted unchanged.
  - s = 1..21: invert position s, then extract data. out_corrected=1. A parity-position hit leaves the data unchanged but is still counted as corrected.
  - s = 22..31: no bit flipped; data extracted as received. out_uncorrectable=1.
  - Double errors yielding s ≤ 21 are miscorrected. This is an accepted limitation (SEC only, no DED).
- Pipeline:
  - S1 registers in_code and the syndrome.
  - S2 registers out_data, out_syndrome and the flags.
  - Latency is 2 cycles from the input handshake to out_valid when unstalled.
  - Sustains 1 word per cycle.
- Flow control:
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1. The combinational ready chain is permitted.
  - A stage loads when it advances. Its valid bit takes the valid of the stage before it.
  - The input transfers when in_valid & in_ready.
  - While out_valid=1 and out_ready=0, all S2 outputs hold stable.
  - S1 fills only if empty; with both stages full, in_ready=0.
  - No bubbles are inserted when out_ready stays 1.
- Counters:
  - Increment on an output handshake (out_valid & out_ready) when the matching flag is 1.
  - Saturate at all-ones; no wrap.
  - clr_cnt zeroes both counters and has priority over a same-cycle increment.
- Reset: in_ready, out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable, corr_cnt and uncorr_cnt all go to 0, and both stage valids clear.
  - Words in flight during reset are discarded.
  - in_ready returns to 1 on the first cycle after rst deasserts.
- Flags and out_syndrome are don't-care semantics while out_valid=0, but are held at their last value (not X).

Test Plan:
- Clean word: in_code=21'h0A786C (encoder output for m=16'h578D) → 2 cycles later out_data=16'h578D, out_syndrome=0, both flags 0, counters unchanged.
- Single data error: in_code=21'h0A686C (position 13 flipped) → out_data=16'h578D, out_syndrome=13, out_corrected=1, corr_cnt=1. Repeat for every p=1..21: syndrome=p, data=16'h578D.
- Uncorrectable: in_code=21'h1A786E (positions 2 and 21 flipped) → out_syndrome=23, out_uncorrectable=1, out_data taken from the raw bits, uncorr_cnt=1.
- Backpressure: stream 4 words with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepts; S2 holds the first result stable.
  - After out_ready=1, all 4 results emerge in order with no loss or duplication.
- Throughput and reset: back-to-back words with out_ready=1 → one result per cycle after a 2-cycle fill. Assert rst mid-stream → out_valid=0, counters=0, in_ready=1 on the cycle after release.
- Counter edges:
  - Force corr_cnt to all-ones via CNT_W=2 and 4 corrected words → holds at 3.
  - clr_cnt concurrent with a corrected handshake → corr_cnt=0.
